magic_device_reader: RTL
========================

# magic_device_reader

Request sequencer placed directly upstream of `MagicDeviceBlackbox`. It accepts 12-bit select requests from the core-side CSR/MMIO path and drives the device's `read_select`/`read_ready` handshake. It captures `read_data` on `read_valid` and returns one registered response per request. A timeout watchdog bounds every device access, and two saturating counters record completed reads and timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 256: maximum cycles `read_ready` is held before an access is abandoned; minimum 2.
- `CNT_W`, default 32: width of the statistics counters.
- `clock`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_select`  in  12  device register index.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  response consumed when `resp_valid && resp_ready`.
- `resp_data`  out  64  captured `read_data`; 0 on timeout.
- `resp_err`  out  1  1 means the access timed out.
- `read_select`  out  12  to device.
- `read_ready`  out  1  to device; read request strobe.
- `read_valid`  in  1  from device.
- `read_data`  in  64  from device.
- `stat_reads`  out  CNT_W  saturating count of successful reads.
- `stat_timeouts`  out  CNT_W  saturating count of timeouts.

## Operation
- FSM states are IDLE, ISSUE and RESP.
- **IDLE:** `req_ready`=1. On request handshake, latch `req_select` into `sel_q`, clear the timer and go to ISSUE.
- **ISSUE:** `read_ready`=1 and `read_select`=`sel_q`, both held stable. The timer increments each cycle.
  - If `read_valid`=1: latch `read_data`, set `err`=0, increment `stat_reads`, go to RESP.
  - Else if timer == `TIMEOUT_CYCLES`-1: set data=0 and `err`=1, increment `stat_timeouts`, go to RESP.
  - If `read_valid` and the timeout fall in the same cycle, `read_valid` wins.
- **RESP:** `resp_valid`=1. On `resp_ready`, return to IDLE.
  - There is no IDLE bypass. At most one request is outstanding, so `req_ready`=0 in ISSUE and RESP.
- **Ignored inputs:** `read_valid` outside ISSUE is ignored and is not counted. Device data is sampled only in ISSUE.
- **Counters:** saturate at all-ones and never wrap.
- **Reset mid-operation:** returns to IDLE and drops any in-flight access and pending response. The device sees `read_ready` fall on the next edge.
- **Reset values:** `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_err`=0, `read_ready`=0, `read_select`=0, both counters 0, timer 0.

## Timing
- All outputs are registered or decoded from FSM state only; there is no combinational path from `req_*` or `read_*` to any output.
- **Request to device:** request handshake at cycle N puts `read_ready`=1 at N+1.
- **Device to response:** `read_valid` at cycle M gives `resp_valid`=1 at M+1 and `read_ready`=0 at M+1.
- **Best-case turnaround:** device responds in its first ISSUE cycle. Then request handshake to `resp_valid` is 2 cycles, and the next request can be accepted 1 cycle after the response handshake.
- **Timeout:** `resp_valid` rises exactly `TIMEOUT_CYCLES`+1 cycles after the request handshake.
- `read_select` keeps its last value outside ISSUE; it is don't-care to the device.

## Structure
- Shared package `magic_dev_pkg` holds:
  - FSM enum `md_state_e` (IDLE, ISSUE, RESP);
  - `MD_SEL_W`=12 and `MD_DATA_W`=64.
- One sub-module, `sat_counter`, parameterised by width with an increment enable. It is instantiated twice, for `stat_reads` and `stat_timeouts`.
- Timer width is `$clog2(TIMEOUT_CYCLES)`.

## Test plan
- **Basic read:** request select 0x123; device asserts `read_valid` with data 0xDEADBEEF_CAFEF00D on its first ISSUE cycle. Expect `resp_valid` 2 cycles after the handshake, that data, `resp_err`=0, `stat_reads`=1.
- **Timeout:** `TIMEOUT_CYCLES`=4 and the device never responds. Expect `read_ready` high for exactly 4 cycles, then `resp_err`=1, `resp_data`=0, `stat_timeouts`=1.
- **Timeout tie:** `read_valid` on the final timeout cycle. Expect `resp_err`=0, data captured, `stat_timeouts` unchanged.
- **Backpressure:** `resp_ready`=0 for 10 cycles while a new `req_valid` is held. Expect `req_ready`=0 and the response stable throughout; the new request is accepted 1 cycle after the response handshake.
- **Reset mid-access:** reset asserted in ISSUE. Expect `read_ready`=0 and `resp_valid`=0 on the next edge, counters 0, and a subsequent read that completes normally.
- **Saturation:** `CNT_W`=2, five successful reads. Expect `stat_reads`=3. A stray `read_valid` in IDLE is not counted.

Source files
------------

// File: rtl/magic_dev_pkg.sv
// ---------------------------------------------------------------------------
// magic_dev_pkg
// Shared definitions for the MagicDeviceBlackbox request sequencer.
//   md_state_e : sequencer FSM states (IDLE, ISSUE, RESP)
//   MD_SEL_W   : device register index width
//   MD_DATA_W  : device read data width
// ---------------------------------------------------------------------------
package magic_dev_pkg;

    localparam int MD_SEL_W  = 12;
    localparam int MD_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } md_state_e;

endpackage : magic_dev_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clock   : rising-edge clock
//   reset   : synchronous, active-high; clears the count
//   inc_i   : add one to the count this cycle (ignored once saturated)
//   count_o : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/magic_device_reader.sv
// ---------------------------------------------------------------------------
// magic_device_reader
// Single-outstanding request sequencer in front of MagicDeviceBlackbox.
// Accepts a select request, holds read_ready/read_select to the device until
// read_valid or a timeout, then presents one registered response.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   req_*          : request channel from the core (valid/ready/select)
//   resp_*         : response channel to the core (valid/ready/data/err)
//   read_*         : device handshake (select/ready out, valid/data in)
//   stat_reads     : saturating count of successful reads
//   stat_timeouts  : saturating count of abandoned (timed-out) accesses
// Every output is a flop or a decode of the FSM state; no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module magic_device_reader
    import magic_dev_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [MD_SEL_W-1:0]  req_select,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [MD_DATA_W-1:0] resp_data,
    output logic                 resp_err,
    output logic [MD_SEL_W-1:0]  read_select,
    output logic                 read_ready,
    input  logic                 read_valid,
    input  logic [MD_DATA_W-1:0] read_data,
    output logic [CNT_W-1:0]     stat_reads,
    output logic [CNT_W-1:0]     stat_timeouts
);

    localparam int             TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    md_state_e              state_q, state_d;
    logic [MD_SEL_W-1:0]    sel_q,   sel_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [MD_DATA_W-1:0]   data_q,  data_d;
    logic                   err_q,   err_d;

    logic                   read_done;
    logic                   time_out;

    // read_valid takes priority over an expiring timer in the same cycle.
    assign read_done = (state_q == ISSUE) && read_valid;
    assign time_out  = (state_q == ISSUE) && !read_valid && (timer_q == TMR_LAST);

    // NOTE: every always_comb output is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        timer_d = timer_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sel_d   = req_select;
                    timer_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = timer_q + TMR_W'(1);
                if (read_done) begin
                    data_d  = read_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (time_out) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign read_ready  = (state_q == ISSUE);
    assign resp_valid  = (state_q == RESP);
    assign read_select = sel_q;
    assign resp_data   = data_q;
    assign resp_err    = err_q;

    sat_counter #(.WIDTH(CNT_W)) u_reads_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (read_done),
        .count_o (stat_reads)
    );

    sat_counter #(.WIDTH(CNT_W)) u_timeouts_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (time_out),
        .count_o (stat_timeouts)
    );

endmodule : magic_device_reader
